// File: rtl/intersection_sequencer.sv
// Intersection sequencer: one FSM drives both the main-road and side-road
// lights, so the two roads can never show green or yellow at the same time.
// The main road rests on green. A latched side request starts a side phase,
// and that phase may have its green extended once.
// Light encoding: 0=off 1=red 2=yellow 3=green.
module intersection_sequencer #(
  parameter int TBASE = 6,  // side green base time; main minimum green is 2*TBASE
  parameter int TYEL  = 2,  // yellow time (>=1)
  parameter int TEXT  = 3,  // one-shot side green extension (>=1)
  parameter int TCLR  = 1,  // all-red clearance between phases (>=1)
  parameter int CW    = 5   // phase counter width, must hold 2*TBASE-1
) (
  input  logic       clk,
  input  logic       reset,       // asynchronous, active-low
  input  logic       sensor,
  output logic [1:0] main_light,
  output logic [1:0] side_light,
  output logic       side_req,
  output logic       phase_start
);

  typedef enum logic [2:0] {
    INIT = 3'd0,
    MG   = 3'd1,
    MY   = 3'd2,
    CR1  = 3'd3,
    SG   = 3'd4,
    SY   = 3'd5,
    CR2  = 3'd6
  } state_t;

  // Last count value of each timed state; a state lasting T exits at T-1.
  localparam logic [CW-1:0] MG_LAST   = CW'(2 * TBASE - 1);
  localparam logic [CW-1:0] BASE_LAST = CW'(TBASE - 1);
  localparam logic [CW-1:0] YEL_LAST  = CW'(TYEL - 1);
  localparam logic [CW-1:0] EXT_LAST  = CW'(TEXT - 1);
  localparam logic [CW-1:0] CLR_LAST  = CW'(TCLR - 1);

  localparam logic [1:0] L_OFF = 2'd0;
  localparam logic [1:0] L_RED = 2'd1;
  localparam logic [1:0] L_YEL = 2'd2;
  localparam logic [1:0] L_GRN = 2'd3;

  state_t        state;
  state_t        next_state;
  logic [CW-1:0] count;
  logic          ext_used;
  logic          restart;    // state entry (including SG re-entry): zero the count
  logic          ext_take;   // grant the single side green extension this edge
  logic          enter_sg;

  // Next-state decision from the registered state, phase count and request.
  always_comb begin
    // NOTE: every signal gets a default before the case so no latch is inferred.
    next_state = state;
    ext_take   = 1'b0;
    unique case (state)
      INIT: next_state = MG;
      MG:   if (count >= MG_LAST && side_req) next_state = MY;
      MY:   if (count == YEL_LAST) next_state = CR1;
      CR1:  if (count == CLR_LAST) next_state = SG;
      SG: begin
        if (!ext_used && count == BASE_LAST) begin
          if (sensor) ext_take   = 1'b1;
          else        next_state = SY;
        end else if (ext_used && count == EXT_LAST) begin
          next_state = SY;
        end
      end
      SY:   if (count == YEL_LAST) next_state = CR2;
      CR2:  if (count == CLR_LAST) next_state = MG;
      default: next_state = CR2;  // unused encoding: fall back to all-red clearance
    endcase
  end

  assign restart  = (next_state != state) || ext_take;
  assign enter_sg = (next_state == SG) && (state != SG);

  // State, phase counter, extension flag, request latch and entry pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= INIT;
      count       <= '0;
      ext_used    <= 1'b0;
      side_req    <= 1'b0;
      phase_start <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state <= next_state;

      if (restart)                              count <= '0;
      else if (state == MG && count >= MG_LAST) count <= count;  // saturate at rest
      else                                      count <= count + CW'(1);

      if (enter_sg)      ext_used <= 1'b0;
      else if (ext_take) ext_used <= 1'b1;

      // Clearing on SG entry wins over a sensor set on the same edge.
      if (enter_sg)                     side_req <= 1'b0;
      else if (sensor && state != SG)   side_req <= 1'b1;

      phase_start <= restart;
    end
  end

  // Lights are decoded from the registered state only.
  always_comb begin
    main_light = L_RED;
    side_light = L_RED;
    unique case (state)
      INIT: begin main_light = L_OFF; side_light = L_OFF; end
      MG:   main_light = L_GRN;
      MY:   main_light = L_YEL;
      SG:   side_light = L_GRN;
      SY:   side_light = L_YEL;
      default: ;  // CR1, CR2 and unused encodings stay all-red
    endcase
  end

endmodule

// File: tb/tb_intersection_sequencer.sv
// Self-checking bench for intersection_sequencer. A behavioural model counts
// elapsed cycles per phase; its expected outputs go into a scoreboard queue
// when the sensor is driven and are compared once the DUT has clocked.
module tb_intersection_sequencer;

  localparam int TBASE = 6;
  localparam int TYEL  = 2;
  localparam int TEXT  = 3;
  localparam int TCLR  = 1;

  // {main_light, side_light} pairs
  localparam logic [3:0] P_MG = 4'hD;
  localparam logic [3:0] P_MY = 4'h9;
  localparam logic [3:0] P_CR = 4'h5;
  localparam logic [3:0] P_SG = 4'h7;
  localparam logic [3:0] P_SY = 4'h6;

  localparam int S_INIT = 0, S_MG = 1, S_MY = 2, S_CR1 = 3, S_SG = 4, S_SY = 5, S_CR2 = 6;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       sensor = 1'b0;
  logic [1:0] main_light;
  logic [1:0] side_light;
  logic       side_req;
  logic       phase_start;

  intersection_sequencer #(
    .TBASE(TBASE), .TYEL(TYEL), .TEXT(TEXT), .TCLR(TCLR), .CW(5)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .sensor     (sensor),
    .main_light (main_light),
    .side_light (side_light),
    .side_req   (side_req),
    .phase_start(phase_start)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int m_st;
  int m_age;   // cycles spent in the current state, 1 in the first cycle
  bit m_ext;
  bit m_req;
  bit m_ps;

  function automatic logic [3:0] lights_of(input int st);
    case (st)
      S_INIT:  return 4'h0;
      S_MG:    return P_MG;
      S_MY:    return P_MY;
      S_SG:    return P_SG;
      S_SY:    return P_SY;
      default: return P_CR;
    endcase
  endfunction

  task automatic model_reset();
    m_st = S_INIT; m_age = 1; m_ext = 0; m_req = 0; m_ps = 0;
  endtask

  task automatic model_step(input logic s);
    int nst;
    int dur;
    bit entered;
    nst = m_st;
    entered = 0;
    case (m_st)
      S_INIT: nst = S_MG;
      S_MG:   if (m_age >= 2 * TBASE && m_req) nst = S_MY;
      S_MY:   if (m_age == TYEL) nst = S_CR1;
      S_CR1:  if (m_age == TCLR) nst = S_SG;
      S_SG: begin
        dur = m_ext ? TEXT : TBASE;
        if (m_age == dur) begin
          if (!m_ext && s) begin entered = 1; m_ext = 1; end
          else nst = S_SY;
        end
      end
      S_SY:   if (m_age == TYEL) nst = S_CR2;
      S_CR2:  if (m_age == TCLR) nst = S_MG;
      default: nst = S_CR2;
    endcase
    if (nst != S_SG || m_st == S_SG) begin
      if (s && m_st != S_SG) m_req = 1;
    end else begin
      m_req = 0;
      m_ext = 0;
    end
    if (nst != m_st) entered = 1;
    m_st  = nst;
    m_age = entered ? 1 : m_age + 1;
    m_ps  = entered;
  endtask

  // ---------------- scoreboard and monitors ----------------
  logic [5:0] exp_q[$];

  typedef struct {
    logic [3:0] l;
    int         n;
  } run_t;
  run_t       run_q[$];
  logic [3:0] run_lights;
  int         run_len;
  logic [3:0] prev1, prev2;

  task automatic observe();
    logic [5:0] e;
    logic [3:0] cur;
    run_t       r;
    cur = {main_light, side_light};
    if (exp_q.size() == 0) begin
      check("scoreboard_underflow", 32'(exp_q.size()), 32'd1);
    end else begin
      e = exp_q.pop_front();
      check("outputs", {26'd0, main_light, side_light, side_req, phase_start}, {26'd0, e});
    end
    check("no_conflict", 32'(main_light >= 2'd2 && side_light >= 2'd2), 32'd0);
    if (side_light == 2'd3 && prev1[1:0] != 2'd3) begin
      check("sg_prev_all_red", 32'(prev1), 32'(P_CR));
      check("sg_prev_prev_main_yellow", 32'(prev2[3:2]), 32'd2);
    end
    if (cur == run_lights) begin
      run_len++;
    end else begin
      if (run_lights != 4'h0) begin
        r.l = run_lights; r.n = run_len;
        run_q.push_back(r);
      end
      run_lights = cur;
      run_len = 1;
    end
    prev2 = prev1;
    prev1 = cur;
  endtask

  // One clock: drive the sensor, predict, then compare after the edge.
  task automatic cycle(input logic s);
    sensor = s;
    model_step(s);
    exp_q.push_back({lights_of(m_st), m_req, m_ps});
    @(posedge clk);
    #1;
    observe();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    exp_q.delete();
    run_q.delete();
    model_reset();
    run_lights = 4'h0; run_len = 0; prev1 = 4'h0; prev2 = 4'h0;
    check("reset_outputs", {26'd0, main_light, side_light, side_req, phase_start}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic check_run(input int i, input logic [3:0] l, input int n);
    if (i >= run_q.size()) begin
      check("run_missing", 32'(run_q.size()), 32'(i + 1));
    end else begin
      check($sformatf("run%0d_lights", i), 32'(run_q[i].l), 32'(l));
      check($sformatf("run%0d_len", i), 32'(run_q[i].n), 32'(n));
    end
  endtask

  initial begin
    // 1: rest on main green with no demand
    do_reset();
    cycle(1'b0);
    check("t1_first_main", 32'(main_light), 32'd3);
    check("t1_first_pulse", 32'(phase_start), 32'd1);
    repeat (40) cycle(1'b0);
    check("t1_main_rest", 32'(main_light), 32'd3);
    check("t1_no_req", 32'(side_req), 32'd0);

    // 2: single sensor pulse in MG cycle 3
    do_reset();
    repeat (3) cycle(1'b0);
    cycle(1'b1);
    check("t2_req_latched", 32'(side_req), 32'd1);
    repeat (30) cycle(1'b0);
    check_run(0, P_MG, 12);
    check_run(1, P_MY, 2);
    check_run(2, P_CR, 1);
    check_run(3, P_SG, 6);
    check_run(4, P_SY, 2);
    check_run(5, P_CR, 1);

    // 3: sensor held high, one extension only, immediate re-request
    do_reset();
    repeat (45) cycle(1'b1);
    check_run(0, P_MG, 12);
    check_run(3, P_SG, TBASE + TEXT);
    check_run(4, P_SY, 2);
    check_run(6, P_MG, 12);

    // 4: first request long after MG saturation
    do_reset();
    repeat (30) cycle(1'b0);
    cycle(1'b1);
    repeat (5) cycle(1'b0);
    check_run(0, P_MG, 31);
    check_run(1, P_MY, 2);

    // 5: asynchronous reset in SG cycle 2
    do_reset();
    repeat (3) cycle(1'b0);
    cycle(1'b1);
    repeat (13) cycle(1'b0);
    check("t5_in_sg", 32'({main_light, side_light}), 32'(P_SG));
    do_reset();
    cycle(1'b0);
    check("t5_restart_mg", 32'({main_light, side_light}), 32'(P_MG));
    repeat (5) cycle(1'b0);

    // 6: random sensor traffic with invariant monitors running
    do_reset();
    for (int i = 0; i < 10000; i++) begin
      if ((i / 500) % 2 == 0) cycle(logic'($urandom_range(0, 19) == 0));
      else                    cycle(logic'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
